// File: rtl/hpf_drv_pkg.sv
// Shared types for the highpass frame driver: FSM state encoding, pixel type and frame-size helper.
package hpf_drv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PROCESS = 3'd2,
        DONE    = 3'd3,
        ERR     = 3'd4
    } state_t;

    typedef logic [7:0] pixel_t;

    function automatic int npix(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/highpass_frame_driver_if.sv
// Load/process link between the frame driver (master) and the highpass filter (slave).
interface highpass_frame_driver_if;
    import hpf_drv_pkg::*;

    pixel_t image_input;
    logic   enable;
    logic   enable_process;
    pixel_t image_output;
    logic   finish;

    modport master (
        output image_input,
        output enable,
        output enable_process,
        input  image_output,
        input  finish
    );

    modport slave (
        input  image_input,
        input  enable,
        input  enable_process,
        output image_output,
        output finish
    );

endinterface

// File: rtl/hpf_drv_ram.sv
// Simple dual-port pixel RAM: one write port, one read port with a registered (read-first) output.
module hpf_drv_ram
    import hpf_drv_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  pixel_t        wdata_i,
    input  logic [AW-1:0] raddr_i,
    output pixel_t        rdata_o
);

    pixel_t mem_q [DEPTH];
    pixel_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset so the host sees 0 after reset; contents are left alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/highpass_frame_driver.sv
// Streams one frame from the frame buffer into the highpass filter and captures its output stream.
// Optional build macro HPF_DRV_CHECKSUM_EN adds csum_o, the mod-2^16 sum of captured pixels.
module highpass_frame_driver
    import hpf_drv_pkg::*;
#(
    parameter  int IMG_W   = 64,
    parameter  int IMG_H   = 64,
    parameter  int TIMEOUT = 1048576,
    localparam int NPIX    = npix(IMG_W, IMG_H),
    localparam int ADDR_W  = $clog2(NPIX)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      host_we_i,
    input  logic [ADDR_W-1:0]         host_addr_i,
    input  pixel_t                    host_wdata_i,
    output pixel_t                    host_rdata_o,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o,
    output logic [ADDR_W:0]           out_count_o,
`ifdef HPF_DRV_CHECKSUM_EN
    output logic [15:0]               csum_o,
`endif
    highpass_frame_driver_if.master   flt
);

    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] NPIX_C   = (ADDR_W + 1)'(NPIX);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t            state_q;
    logic [ADDR_W:0]   ld_idx_q;
    logic [ADDR_W:0]   ld_idx_d;
    logic [ADDR_W:0]   cnt_q;
    logic [TMO_W-1:0]  tmo_q;
    pixel_t            image_input_q;
    logic              enable_q;
    logic              enable_process_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    pixel_t            frame_rdata;
    logic              start_ok;
    logic              frame_we;
    logic              result_we;

    assign start_ok  = start_i && (state_q inside {IDLE, DONE, ERR});
    assign frame_we  = host_we_i && !(state_q inside {LOAD, PROCESS});
    assign result_we = (state_q == PROCESS) && !flt.finish && (cnt_q != NPIX_C);

    // The frame buffer is addressed with the next index so its registered output lines up
    // with enable on the following edge.
    always_comb begin
        ld_idx_d = ld_idx_q;
        if (start_ok) begin
            ld_idx_d = '0;
        end else if (state_q == LOAD) begin
            ld_idx_d = ld_idx_q + (ADDR_W + 1)'(1);
        end
    end

    hpf_drv_ram #(.DEPTH(NPIX), .AW(ADDR_W)) u_frame_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (frame_we),
        .waddr_i (host_addr_i),
        .wdata_i (host_wdata_i),
        .raddr_i (ld_idx_d[ADDR_W-1:0]),
        .rdata_o (frame_rdata)
    );

    hpf_drv_ram #(.DEPTH(NPIX), .AW(ADDR_W)) u_result_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (result_we),
        .waddr_i (cnt_q[ADDR_W-1:0]),
        .wdata_i (flt.image_output),
        .raddr_i (host_addr_i),
        .rdata_o (host_rdata_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            ld_idx_q         <= '0;
            cnt_q            <= '0;
            tmo_q            <= '0;
            image_input_q    <= '0;
            enable_q         <= 1'b0;
            enable_process_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            error_q          <= 1'b0;
        end else begin
            ld_idx_q <= ld_idx_d;
            case (state_q)
                IDLE, DONE, ERR: begin
                    enable_q         <= 1'b0;
                    enable_process_q <= 1'b0;
                    image_input_q    <= '0;
                    if (start_i) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                LOAD: begin
                    if (ld_idx_q == NPIX_C) begin
                        // enable falls and enable_process rises on the same edge
                        state_q          <= PROCESS;
                        enable_q         <= 1'b0;
                        enable_process_q <= 1'b1;
                        image_input_q    <= '0;
                        tmo_q            <= '0;
                    end else begin
                        enable_q      <= 1'b1;
                        image_input_q <= frame_rdata;
                    end
                end
                PROCESS: begin
                    if (flt.finish) begin
                        state_q          <= DONE;
                        enable_process_q <= 1'b0;
                        busy_q           <= 1'b0;
                        done_q           <= 1'b1;
                    end else begin
                        if (cnt_q != NPIX_C) begin
                            cnt_q <= cnt_q + (ADDR_W + 1)'(1);
                        end
                        if (tmo_q == TMO_LAST) begin
                            state_q          <= ERR;
                            enable_process_q <= 1'b0;
                            busy_q           <= 1'b0;
                            error_q          <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef HPF_DRV_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (start_ok) begin
            csum_q <= '0;
        end else if (result_we) begin
            csum_q <= csum_q + 16'(flt.image_output);
        end
    end

    assign csum_o = csum_q;
`endif

    assign flt.image_input    = image_input_q;
    assign flt.enable         = enable_q;
    assign flt.enable_process = enable_process_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign error_o            = error_q;
    assign out_count_o        = cnt_q;

endmodule

// File: tb/tb_highpass_frame_driver.sv
// Directed bench for highpass_frame_driver on a 4x4 frame with a behavioural filter and reference model.
module tb_highpass_frame_driver;
    import hpf_drv_pkg::*;

    localparam int NP  = 16;
    localparam int AW  = 4;
    localparam int TMO = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    pixel_t        host_wdata = '0;
    pixel_t        host_rdata;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   out_count;
`ifdef HPF_DRV_CHECKSUM_EN
    logic [15:0]   csum;
`endif

    highpass_frame_driver_if flt();

    always #5 clk = ~clk;

    highpass_frame_driver #(.IMG_W(4), .IMG_H(4), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_we_i    (host_we),
        .host_addr_i  (host_addr),
        .host_wdata_i (host_wdata),
        .host_rdata_o (host_rdata),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .out_count_o  (out_count),
`ifdef HPF_DRV_CHECKSUM_EN
        .csum_o       (csum),
`endif
        .flt          (flt)
    );

    int     checks = 0;
    int     errors = 0;
    pixel_t frame_m  [NP];
    pixel_t result_m [NP];
    int     exp_cnt = 0;
    int     csum_m  = 0;
    int     load_k  = 0;
    logic   prev_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    // Cycle-by-cycle compare against the model: load stream order/length and result count.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
            load_k  = 0;
        end else begin
            if (flt.enable) begin
                chk("en_ep_excl", 32'(flt.enable_process), 32'd0);
                chk("load_busy", 32'(busy), 32'd1);
                if (load_k < NP) chk("load_pix", 32'(flt.image_input), 32'(frame_m[load_k]));
                else             chk("load_extra", 32'(load_k), 32'(NP - 1));
                load_k++;
            end else if (!busy) begin
                load_k = 0;
            end
            if (prev_en && !flt.enable) begin
                chk("en_to_ep", 32'(flt.enable_process), 32'd1);
                chk("load_len", 32'(load_k), 32'(NP));
            end
            chk("out_count", 32'(out_count), 32'(exp_cnt));
            prev_en = flt.enable;
        end
    end

    task automatic start_xfer();
        start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        exp_cnt = 0;
        csum_m  = 0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_err_clr", 32'(error), 32'd0);
        chk("start_en_lat", 32'(flt.enable), 32'd0);
        @(posedge clk); #1;
        chk("en_rise", 32'(flt.enable), 32'd1);
    endtask

    // Behavioural filter: returns mul*j+add for each process cycle, then optionally finish.
    task automatic run_filter(input int n_ret, input bit do_fin, input int mul, input int add,
                              input bit poke, output int epc);
        int     t = 0;
        int     j = 0;
        pixel_t p;
        epc = 0;
        while (!flt.enable_process && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("ep_rise", 32'(flt.enable_process), 32'd1);
        if (flt.enable_process) begin
            while (j < 200) begin
                if (do_fin && j == n_ret) begin
                    flt.finish       = 1'b1;
                    flt.image_output = 8'hEE;
                    @(posedge clk); #1;
                    flt.finish = 1'b0;
                    break;
                end
                p = pixel_t'(mul * j + add);
                flt.image_output = p;
                if (poke && j == 3) begin
                    host_we    = 1'b1;
                    host_addr  = '0;
                    host_wdata = 8'hAA;
                    start      = 1'b1;
                end
                @(posedge clk); #1;
                host_we = 1'b0;
                start   = 1'b0;
                if (j < NP) begin
                    result_m[j] = p;
                    csum_m += int'(p);
                end
                exp_cnt = (j + 1 < NP) ? j + 1 : NP;
                epc++;
                j++;
                if (!flt.enable_process) break;
            end
        end
    endtask

    task automatic host_read(input string nm, input int a, input int exp);
        host_addr = AW'(a);
        @(posedge clk); #1;
        chk(nm, 32'(host_rdata), 32'(exp));
    endtask

    task automatic chk_idle_done(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ep"}, 32'(flt.enable_process), 32'd0);
        chk({tag, "_img"}, 32'(flt.image_input), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_img"}, 32'(flt.image_input), 32'd0);
        chk({tag, "_en"}, 32'(flt.enable), 32'd0);
        chk({tag, "_ep"}, 32'(flt.enable_process), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(error), 32'd0);
        chk({tag, "_cnt"}, 32'(out_count), 32'd0);
        chk({tag, "_rdata"}, 32'(host_rdata), 32'd0);
`ifdef HPF_DRV_CHECKSUM_EN
        chk({tag, "_csum"}, 32'(csum), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int epc;
        int t;
        flt.image_output = '0;
        flt.finish       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NP; i++) begin
            frame_m[i] = pixel_t'(i);
            host_we    = 1'b1;
            host_addr  = AW'(i);
            host_wdata = pixel_t'(i);
            @(posedge clk); #1;
        end
        host_we = 1'b0;
        $display("frame ramp 0..15 written");

        // Ramp load followed by 16 returned pixels and finish
        start_xfer();
        chk("first_pix", 32'(flt.image_input), 32'd0);
        run_filter(16, 1'b1, 3, 5, 1'b0, epc);
        chk_idle_done("t2");
        chk("t2_cnt", 32'(out_count), 32'd16);
        for (int i = 0; i < NP; i++) host_read("t2_rd", i, int'(result_m[i]));
        host_read("t2_rd15_lit", 15, 50);
        $display("xfer 16 px: out_count=%0d done=%0d", out_count, done);

        // Filter returns 20 pixels: count saturates, no wrap into slot 0
        start_xfer();
        run_filter(20, 1'b1, 11, 1, 1'b0, epc);
        chk_idle_done("t3");
        chk("t3_cnt", 32'(out_count), 32'd16);
        for (int i = 0; i < NP; i++) host_read("t3_rd", i, int'(result_m[i]));
        host_read("t3_rd15_lit", 15, 166);
        host_read("t3_rd0_lit", 0, 1);
        $display("xfer 20 px: out_count=%0d", out_count);

        // No finish: timeout after exactly TMO process cycles, start clears error
        start_xfer();
        run_filter(0, 1'b0, 7, 9, 1'b0, epc);
        chk("t4_ep_cycles", 32'(epc), 32'(TMO));
        chk("t4_err", 32'(error), 32'd1);
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        $display("timeout xfer: ep cycles=%0d error=%0d", epc, error);
        start_xfer();
        run_filter(16, 1'b1, 2, 0, 1'b0, epc);
        chk_idle_done("t4b");

        // Reset while pixel 7 is on the bus aborts at once; next start replays from pixel 0
        start_xfer();
        t = 0;
        while (load_k < 7 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("t5_k7", 32'(flt.image_input), 32'd7);
        #2;
        rst_n   = 1'b0;
        exp_cnt = 0;
        #1;
        chk_zero("t5_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("reset mid-load at pixel 7");
        start_xfer();
        chk("t5_replay0", 32'(flt.image_input), 32'd0);
        run_filter(16, 1'b1, 5, 3, 1'b0, epc);
        chk_idle_done("t5");

        // host_we and start during PROCESS are ignored
        start_xfer();
        run_filter(16, 1'b1, 13, 7, 1'b1, epc);
        chk_idle_done("t6");
        chk("t6_cnt", 32'(out_count), 32'd16);
`ifdef HPF_DRV_CHECKSUM_EN
        chk("t6_csum", 32'(csum), 32'(csum_m & 16'hFFFF));
`endif
        for (int i = 0; i < NP; i++) host_read("t6_rd", i, int'(result_m[i]));
        start_xfer();
        chk("t6_frame0_kept", 32'(flt.image_input), 32'd0);
        run_filter(16, 1'b1, 1, 100, 1'b0, epc);
        chk_idle_done("t6b");
        $display("busy poke xfer: out_count=%0d", out_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
